rom_play_ctrl: RTL
==================

Name: rom_play_ctrl

Overview:
- Sequences the address port of a single-port synchronous ROM (8-bit address, 8-bit data) from two debounced key pulses.
- Supports auto-play at a programmable rate, pause, single-step and direction reversal.
- Compensates for the ROM's registered read latency. Captures each returned word into a holding register with a one-cycle valid pulse for the dynamic seven-segment display path.
- Sits between the key_filter instances and the ROM/display pair.

Parameters:
- CNT_MAX, 23'd4_999_999, last count of the auto-play tick counter; the address advances every CNT_MAX+1 cycles.
- ADDR_MIN, 8'd0, lower address bound (inclusive).
- ADDR_MAX, 8'd255, upper address bound (inclusive); must be >= ADDR_MIN.
- RD_LAT, 1, ROM clock-to-q latency in cycles, measured from the rom_addr change. Legal range 1..3.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- key1_flag  input  1  one-cycle pulse: play/pause toggle.
- key2_flag  input  1  one-cycle pulse: step (IDLE/PAUSE) or reverse direction (PLAY).
- rom_q  input  8  ROM read data.
- rom_addr  output  8  registered ROM address.
- disp_data  output  8  last captured ROM word.
- disp_vld  output  1  one-cycle pulse when disp_data updates.
- play_st  output  2  current state: 0 IDLE, 1 PLAY, 2 PAUSE.
- dir  output  1  0 increment, 1 decrement.

Behaviour:
- Reset values: rom_addr=ADDR_MIN, disp_data=0, disp_vld=0, play_st=IDLE, dir=0, tick counter=0, read pipeline cleared.
- Boot read: on the first cycle after reset release, the block issues one read of ADDR_MIN. The display therefore shows rom[ADDR_MIN] without any key press.
- Issuing a read:
  - Every rom_addr update, and the boot read, pushes a token into an RD_LAT-deep shift register.
  - When the token emerges, rom_q is sampled into disp_data and disp_vld=1 for exactly that cycle.
  - Reads may overlap; every issued read produces exactly one capture, in issue order.
- Step:
  - addr_next = addr+1 when dir=0; wraps ADDR_MAX->ADDR_MIN.
  - addr_next = addr-1 when dir=1; wraps ADDR_MIN->ADDR_MAX.
  - Arithmetic is 8-bit, with bounds compared before the add/subtract.
- IDLE:
  - key1 -> PLAY, tick counter cleared.
  - key2 -> one step plus read; stay in IDLE.
- PLAY:
  - Tick counter runs 0..CNT_MAX. On the cycle it equals CNT_MAX: step plus read, counter back to 0.
  - key1 -> PAUSE, counter frozen at its current value.
  - key2 -> dir toggles; the counter is not disturbed. If this coincides with a CNT_MAX tick, that step uses the old dir.
- PAUSE:
  - key1 -> PLAY, counter resumes from its frozen value.
  - key2 -> one step plus read in the current dir; stay in PAUSE.
- Simultaneous key1 and key2 in the same cycle: key1 is acted on, key2 is discarded.
- Reset asserted mid-operation: all state and in-flight read tokens are cleared immediately. The boot read is reissued after release.
- Latency: key2 step in IDLE/PAUSE -> rom_addr changes next cycle -> disp_vld RD_LAT cycles after that.

Optional Feature:
- Macro ROM_PLAY_ONESHOT_EN.
- When defined, auto-play stops at the end bound instead of wrapping:
  - Applies at ADDR_MAX when dir=0, or ADDR_MIN when dir=1.
  - The CNT_MAX tick that would wrap issues no step, and the state returns to IDLE with the counter cleared.
- Manual steps still wrap.
- When undefined, auto-play wraps continuously as described above.

Test Plan:
- Common bench setup: CNT_MAX=9, ADDR_MIN=0, ADDR_MAX=3, RD_LAT=1. ROM model returns {4'h1, addr[3:0]} registered one cycle after the address.
- Reset release -> rom_addr=0, one disp_vld pulse with disp_data=8'h10; play_st=0.
- key1 pulse -> play_st=1. rom_addr steps 1,2,3,0 at 10-cycle intervals; disp_data 8'h11,8'h12,8'h13,8'h10, each arriving 1 cycle after its address change.
- PLAY at rom_addr=2, key2 pulse -> dir=1. Next ticks give rom_addr 1,0,3 (wrap down). Then key1 -> PAUSE; no address change for 50 cycles. Then key2 -> rom_addr 2, disp_data=8'h12.
- key1 and key2 in the same cycle from IDLE -> PLAY entered, dir unchanged, rom_addr unchanged that cycle.
- Assert sys_rst_n low during PLAY with a read in flight -> disp_vld never pulses for the dropped read. After release, rom_addr=0, dir=0, one pulse with 8'h10.
- With ROM_PLAY_ONESHOT_EN defined: PLAY from 0 reaches 3, then on the next tick play_st=0 and rom_addr stays 3. Without the macro: rom_addr wraps to 0.

Source files
------------

// File: rtl/rom_play_ctrl.sv
// ROM address sequencer: auto-play, pause, single-step and reverse from two key pulses.
// Define ROM_PLAY_ONESHOT_EN to stop auto-play at the end bound instead of wrapping.
module rom_play_ctrl #(
  parameter logic [22:0] CNT_MAX  = 23'd4_999_999,
  parameter logic [7:0]  ADDR_MIN = 8'd0,
  parameter logic [7:0]  ADDR_MAX = 8'd255,
  parameter int          RD_LAT   = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key1_flag,
  input  logic       key2_flag,
  input  logic [7:0] rom_q,
  output logic [7:0] rom_addr,
  output logic [7:0] disp_data,
  output logic       disp_vld,
  output logic [1:0] play_st,
  output logic       dir
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  logic [22:0]     cnt, cnt_nxt;
  logic [1:0]      st_nxt;
  logic            dir_nxt;
  logic            step;
  logic            boot_pend;
  logic [RD_LAT:0] vld_pipe;
  logic [7:0]      hold;
  logic [7:0]      addr_step;

  // Bounds are checked before the add/subtract so 8-bit wrap never leaks out.
  always_comb begin
    if (dir) addr_step = (rom_addr == ADDR_MIN) ? ADDR_MAX : rom_addr - 8'd1;
    else     addr_step = (rom_addr == ADDR_MAX) ? ADDR_MIN : rom_addr + 8'd1;
  end

`ifdef ROM_PLAY_ONESHOT_EN
  logic at_end;
  assign at_end = dir ? (rom_addr == ADDR_MIN) : (rom_addr == ADDR_MAX);
`endif

  always_comb begin
    st_nxt  = play_st;
    cnt_nxt = cnt;
    dir_nxt = dir;
    step    = 1'b0;
    case (play_st)
      IDLE: begin
        if (key1_flag) begin
          st_nxt  = PLAY;
          cnt_nxt = '0;
        end else if (key2_flag) begin
          step = 1'b1;
        end
      end
      PLAY: begin
        if (key1_flag) begin
          st_nxt = PAUSE;
        end else begin
          if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
`ifdef ROM_PLAY_ONESHOT_EN
            if (at_end) st_nxt = IDLE;
            else        step   = 1'b1;
`else
            step = 1'b1;
`endif
          end else begin
            cnt_nxt = cnt + 23'd1;
          end
          // step above already used the old dir
          if (key2_flag) dir_nxt = ~dir;
        end
      end
      PAUSE: begin
        if (key1_flag)      st_nxt = PLAY;
        else if (key2_flag) step   = 1'b1;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rom_addr  <= ADDR_MIN;
      play_st   <= IDLE;
      dir       <= 1'b0;
      cnt       <= '0;
      boot_pend <= 1'b1;
      vld_pipe  <= '0;
      hold      <= 8'd0;
    end else begin
      play_st   <= st_nxt;
      dir       <= dir_nxt;
      cnt       <= cnt_nxt;
      boot_pend <= 1'b0;
      if (step) rom_addr <= addr_step;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], step | boot_pend};
      if (vld_pipe[RD_LAT]) hold <= rom_q;
    end
  end

  // Token emerges in the cycle rom_q carries its word; bypass so the display sees it then.
  assign disp_vld  = vld_pipe[RD_LAT];
  assign disp_data = disp_vld ? rom_q : hold;

endmodule
